// File: rtl/stall_ctrl_pkg.sv
// stall_ctrl_pkg
//   Shared types for the pipeline freeze/flush controller.
//   - stall_state_e : controller state (RUN, ERR)
//   - pipe_ctrl_t   : the seven pipeline-register control lines, grouped
//   - PIPE_CTRL_IDLE: every control line deasserted
package stall_ctrl_pkg;

    typedef enum logic {
        RUN = 1'b0,
        ERR = 1'b1
    } stall_state_e;

    typedef struct packed {
        logic pc_freeze;
        logic if_id_freeze;
        logic id_ex_freeze;
        logic ex_mem_freeze;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_bubble;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t PIPE_CTRL_IDLE = '0;

    // Whole pipeline held, MEM/WB fed a bubble: used for memory wait and ERR.
    localparam pipe_ctrl_t PIPE_CTRL_FREEZE = '{
        pc_freeze:     1'b1,
        if_id_freeze:  1'b1,
        id_ex_freeze:  1'b1,
        ex_mem_freeze: 1'b1,
        if_id_flush:   1'b0,
        id_ex_flush:   1'b0,
        mem_wb_bubble: 1'b1
    };

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Saturating up-counter used for the stall performance counters.
//   Ports:
//     clk  in      rising-edge clock
//     rst  in      synchronous active-low reset, clears the count
//     inc  in      count this cycle
//     cnt  out [W] current count, sticks at 2^W-1
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
//   Freeze/flush controller for the five-stage core. Combines the hazard
//   request, EXE taken branch and MEM memory handshake into the pipeline
//   register controls, with a memory-wait watchdog that latches a fatal
//   timeout (state ERR, left only through reset).
//   Optional feature macro: STALL_PERF_CNT_EN adds three saturating
//   performance counters (hazard_cnt, flush_cnt, mem_wait_cnt).
//   Ports:
//     clk, rst (sync, active-low)
//     hazard, branch_taken, mem_req, mem_ready       in
//     pc_freeze, if_id_freeze, id_ex_freeze,
//     ex_mem_freeze, if_id_flush, id_ex_flush,
//     mem_wb_bubble                                   out, combinational
//     mem_timeout                                     out, registered sticky
//     hazard_cnt, flush_cnt, mem_wait_cnt [CNT_W]     out, STALL_PERF_CNT_EN only
module pipeline_stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_freeze,
    output logic             if_id_freeze,
    output logic             id_ex_freeze,
    output logic             ex_mem_freeze,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic             mem_timeout
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] hazard_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] mem_wait_cnt
`endif
);

    // TIMEOUT = 0 still needs a legal 1-bit counter.
    localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    stall_state_e      state, state_nxt;
    pipe_ctrl_t        ctrl, ctrl_out;
    logic [WAIT_W-1:0] wait_ctr;
    logic              mem_stall;
    logic              timeout_hit;

    assign mem_stall   = mem_req & ~mem_ready;
    assign timeout_hit = (TIMEOUT != 0) && (state == RUN) && mem_stall &&
                         (wait_ctr == WAIT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // Next state and priority-encoded controls
    always_comb begin
        state_nxt = state;
        ctrl      = PIPE_CTRL_IDLE;
        if (state == ERR) begin
            ctrl = PIPE_CTRL_FREEZE;
        end else begin
            if (timeout_hit)
                state_nxt = ERR;
            if (mem_stall) begin
                // branch/hazard stay in frozen stages and re-evaluate on release
                ctrl = PIPE_CTRL_FREEZE;
            end else if (branch_taken) begin
                ctrl.if_id_flush = 1'b1;
                ctrl.id_ex_flush = 1'b1;
            end else if (hazard) begin
                ctrl.pc_freeze    = 1'b1;
                ctrl.if_id_freeze = 1'b1;
                ctrl.id_ex_flush  = 1'b1;
            end
        end
    end

    // Outputs are forced quiet for the whole time reset is held.
    assign ctrl_out      = rst ? ctrl : PIPE_CTRL_IDLE;
    assign pc_freeze     = ctrl_out.pc_freeze;
    assign if_id_freeze  = ctrl_out.if_id_freeze;
    assign id_ex_freeze  = ctrl_out.id_ex_freeze;
    assign ex_mem_freeze = ctrl_out.ex_mem_freeze;
    assign if_id_flush   = ctrl_out.if_id_flush;
    assign id_ex_flush   = ctrl_out.id_ex_flush;
    assign mem_wb_bubble = ctrl_out.mem_wb_bubble;

    // Watchdog: run length of consecutive memory-wait cycles, frozen in ERR.
    always_ff @(posedge clk) begin
        if (!rst)
            wait_ctr <= '0;
        else if (state == ERR)
            wait_ctr <= wait_ctr;
        else if (mem_stall)
            wait_ctr <= wait_ctr + 1'b1;
        else
            wait_ctr <= '0;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            mem_timeout <= 1'b0;
        else if (timeout_hit)
            mem_timeout <= 1'b1;
    end

`ifdef STALL_PERF_CNT_EN
    logic hazard_act, flush_act, wait_act;

    assign wait_act   = (state == RUN) & mem_stall;
    assign flush_act  = (state == RUN) & ~mem_stall & branch_taken;
    assign hazard_act = (state == RUN) & ~mem_stall & ~branch_taken & hazard;

    sat_counter #(.W(CNT_W)) u_hazard_cnt (
        .clk (clk), .rst (rst), .inc (hazard_act), .cnt (hazard_cnt)
    );
    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk), .rst (rst), .inc (flush_act), .cnt (flush_cnt)
    );
    sat_counter #(.W(CNT_W)) u_mem_wait_cnt (
        .clk (clk), .rst (rst), .inc (wait_act), .cnt (mem_wait_cnt)
    );
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl
//   Directed scenarios followed by random stimulus, all compared against a
//   behavioural model of the freeze/flush rules, the watchdog and counters.
module tb_pipeline_stall_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 3;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst, hazard, branch_taken, mem_req, mem_ready;
    logic pc_freeze, if_id_freeze, id_ex_freeze, ex_mem_freeze;
    logic if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout;
`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] hazard_cnt, flush_cnt, mem_wait_cnt;
`endif

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .hazard        (hazard),
        .branch_taken  (branch_taken),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .pc_freeze     (pc_freeze),
        .if_id_freeze  (if_id_freeze),
        .id_ex_freeze  (id_ex_freeze),
        .ex_mem_freeze (ex_mem_freeze),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .mem_wb_bubble (mem_wb_bubble),
        .mem_timeout   (mem_timeout)
`ifdef STALL_PERF_CNT_EN
        ,
        .hazard_cnt    (hazard_cnt),
        .flush_cnt     (flush_cnt),
        .mem_wait_cnt  (mem_wait_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    bit m_err;
    int m_run;          // consecutive memory-wait cycles seen
    bit m_to;
    int m_hc, m_fc, m_mc;

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    // One cycle: check registered state, drive inputs, check controls, advance model.
    // Control order: {pc, if_id, id_ex, ex_mem freeze, if_id flush, id_ex flush, bubble}
    task automatic step(input bit r, input bit hz, input bit br, input bit rq, input bit rd);
        logic [6:0] exp_c, got_c;
        bit stall;
        @(negedge clk);
        chk("mem_timeout", {31'd0, mem_timeout}, {31'd0, m_to});
`ifdef STALL_PERF_CNT_EN
        chk("hazard_cnt", 32'(hazard_cnt), 32'(m_hc));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_fc));
        chk("mem_wait_cnt", 32'(mem_wait_cnt), 32'(m_mc));
`endif
        rst = r; hazard = hz; branch_taken = br; mem_req = rq; mem_ready = rd;
        #1;
        stall = rq && !rd;
        if (!r)                 exp_c = 7'b0000000;
        else if (m_err || stall) exp_c = 7'b1111001;
        else if (br)            exp_c = 7'b0000110;
        else if (hz)            exp_c = 7'b1100010;
        else                    exp_c = 7'b0000000;
        got_c = {pc_freeze, if_id_freeze, id_ex_freeze, ex_mem_freeze,
                 if_id_flush, id_ex_flush, mem_wb_bubble};
        chk("ctrl", {25'd0, got_c}, {25'd0, exp_c});
        // state update at the coming edge
        if (!r) begin
            m_err = 0; m_run = 0; m_to = 0; m_hc = 0; m_fc = 0; m_mc = 0;
        end else if (!m_err) begin
            if (stall) begin
                m_run++;
                m_mc = sat_inc(m_mc);
                if (m_run == TIMEOUT) begin
                    m_err = 1;
                    m_to  = 1;
                end
            end else begin
                m_run = 0;
                if (br)      m_fc = sat_inc(m_fc);
                else if (hz) m_hc = sat_inc(m_hc);
            end
        end
    endtask

    task automatic do_reset();
        step(0, 1, 0, 1, 0);   // reset dominates active inputs
        step(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 0; hazard = 0; branch_taken = 0; mem_req = 0; mem_ready = 0;
        m_err = 0; m_run = 0; m_to = 0; m_hc = 0; m_fc = 0; m_mc = 0;

        // Reset, then outputs follow inputs in the release cycle
        do_reset();
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // Hazard for two cycles
        do_reset();
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
`ifdef STALL_PERF_CNT_EN
        chk("dir_hazard_cnt", 32'(hazard_cnt), 32'd2);
`endif

        // Branch masks hazard
        do_reset();
        step(1, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0);
`ifdef STALL_PERF_CNT_EN
        chk("dir_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("dir_hz_masked", 32'(hazard_cnt), 32'd0);
`endif

        // Memory wait 3 cycles, release with pending branch
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 0);
        step(1, 0, 1, 1, 1);
        step(1, 0, 0, 0, 0);
        chk("dir_no_timeout", {31'd0, mem_timeout}, 32'd0);
`ifdef STALL_PERF_CNT_EN
        chk("dir_wait_cnt", 32'(mem_wait_cnt), 32'd3);
`endif

        // Timeout: stall held 10 cycles, ERR persists after ready, reset clears
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++)  step(1, 1, 1, 1, 1);
        chk("dir_timeout_sticky", {31'd0, mem_timeout}, 32'd1);
        chk("dir_err_freeze", {31'd0, pc_freeze}, 32'd1);
        do_reset();
        step(1, 0, 0, 0, 0);
        chk("dir_timeout_clr", {31'd0, mem_timeout}, 32'd0);

        // Stall of TIMEOUT-1 cycles, then one idle cycle: no timeout
        do_reset();
        for (int i = 0; i < TIMEOUT - 1; i++) step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 1);
        chk("dir_run_restart", {31'd0, mem_timeout}, 32'd0);

        // Counter saturation
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
`ifdef STALL_PERF_CNT_EN
        chk("dir_hazard_sat", 32'(hazard_cnt), 32'(CMAX));
`endif

        // Random stimulus
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit r, hz, br, rq, rd;
            r  = ($urandom_range(0, 99) != 0);
            hz = ($urandom_range(0, 2) == 0);
            br = ($urandom_range(0, 4) == 0);
            rq = ($urandom_range(0, 1) == 0);
            rd = ($urandom_range(0, 2) != 0);
            // occasionally force long waits so the watchdog fires
            if ($urandom_range(0, 40) == 0) begin
                for (int j = 0; j < TIMEOUT + 2; j++) step(1, hz, br, 1, 0);
            end
            // escape ERR now and then
            if (m_err && $urandom_range(0, 9) == 0) r = 0;
            step(r, hz, br, rq, rd);
        end
        step(1, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Pipeline freeze/flush controller for the five-stage ARM core. It consumes the hazard indication, the EXE-stage branch decision and the MEM-stage memory handshake, and drives the per-register freeze and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It adds a memory-wait watchdog that latches a fatal timeout and optional saturating performance counters. It sits beside the hazard detector and is the only source of pipeline-register enables.

## Interface
- `TIMEOUT`, 255: consecutive memory-wait cycles before a fatal timeout. 0 disables the watchdog.
- `CNT_W`, 32: width of each performance counter.
- `clk`  in  1  Rising-edge clock; the block has one clock.
- `rst`  in  1  Reset, synchronous and active-low.
- `hazard`  in  1  Load-use or RAW stall request from the hazard detector.
- `branch_taken`  in  1  EXE-stage taken branch.
- `mem_req`  in  1  MEM stage holds a load/store.
- `mem_ready`  in  1  Memory has completed the current access.
- `pc_freeze`  out  1  Hold the PC.
- `if_id_freeze`  out  1  Hold IF/ID.
- `id_ex_freeze`  out  1  Hold ID/EX.
- `ex_mem_freeze`  out  1  Hold EX/MEM.
- `if_id_flush`  out  1  Load a NOP into IF/ID.
- `id_ex_flush`  out  1  Load a bubble into ID/EX, clearing WB_EN, MEM_R/W_EN and S.
- `mem_wb_bubble`  out  1  MEM/WB captures a bubble.
- `mem_timeout`  out  1  Sticky fatal watchdog flag.
- `hazard_cnt`, `flush_cnt`, `mem_wait_cnt`  out  CNT_W  Performance counters. Present only with `STALL_PERF_CNT_EN`.

## Operation
- State machine with states RUN and ERR. Reset enters RUN.
- `mem_stall` = `mem_req & ~mem_ready`.
- Priority from highest to lowest is ERR, then `mem_stall`, then `branch_taken`, then `hazard`, then idle.
- **ERR:** all four freeze outputs are 1 and `mem_wb_bubble` is 1. Both flush outputs are 0. All inputs are ignored. Only reset exits ERR.
- **mem_stall:**
  - All freeze outputs are 1 and `mem_wb_bubble` is 1.
  - Both flush outputs are 0. `branch_taken` and `hazard` are masked because they are held in frozen stages and are re-evaluated on release.
- **branch_taken:** `if_id_flush` and `id_ex_flush` are 1. All freezes are 0. `hazard` is ignored because its instruction is being flushed.
- **hazard:** `pc_freeze`, `if_id_freeze` and `id_ex_flush` are 1. Everything else is 0.
- **Idle:** all outputs are 0.
- **Watchdog:**
  - `wait_ctr` has width clog2(TIMEOUT+1). It increments on each `mem_stall` cycle and clears on any cycle without `mem_stall`.
  - If `mem_stall` is true while `wait_ctr == TIMEOUT-1`, the next state is ERR and `mem_timeout` is set.
  - `wait_ctr` holds its value in ERR.
- **Reset while `rst` is low:** every output is 0 and the state is RUN. `wait_ctr`, all counters and `mem_timeout` are 0. Reset mid-wait or in ERR returns the block to RUN on the next edge.

## Timing
- All freeze and flush outputs are combinational from the inputs and the current state. They take effect in the same cycle as their cause, with zero latency.
- `mem_timeout` is registered. With `mem_stall` high in cycles 1..TIMEOUT, `mem_timeout` rises at the edge ending cycle TIMEOUT. From cycle TIMEOUT+1 the ERR outputs apply.
- Stall release: the first cycle with `mem_ready` high drops all freezes in that same cycle. A pending `branch_taken` or `hazard` is honoured in that cycle.
- A single-cycle `mem_stall` never reaches ERR when TIMEOUT ≥ 2.
- `hazard` held for N cycles produces N cycles of freeze and N bubbles. No internal stall is added.

## Configuration
- `STALL_PERF_CNT_EN` defined: `hazard_cnt`, `flush_cnt` and `mem_wait_cnt` exist.
  - Each counter saturates at 2^CNT_W−1 and clears on reset.
  - `hazard_cnt` increments on cycles where the hazard branch of the priority chain is active.
  - `flush_cnt` increments on cycles where `branch_taken` is active.
  - `mem_wait_cnt` increments on cycles where `mem_stall` is active.
  - No counter increments in ERR.
- `STALL_PERF_CNT_EN` undefined: the counter ports and counter logic are absent. All other behaviour is identical.

## Structure
- The shared package `stall_ctrl_pkg` holds:
  - the state enum (RUN, ERR);
  - a packed struct `pipe_ctrl_t` grouping the seven control outputs;
  - the constant `PIPE_CTRL_IDLE`.
- Sub-module `sat_counter` (parameter W, with `inc`) is instantiated three times for the performance counters.

## Test plan
- **Reset:** `rst`=0 with `hazard`=1 and `mem_req`=1 → all outputs 0. Release `rst` → outputs follow the inputs in the same cycle.
- **Hazard:** `hazard`=1 for 2 cycles → `pc_freeze`, `if_id_freeze` and `id_ex_flush` are 1 for exactly those 2 cycles. `hazard_cnt`=2.
- **Branch with hazard:** `branch_taken`=1 and `hazard`=1 together → `if_id_flush`=1 and `id_ex_flush`=1, `pc_freeze`=0. `flush_cnt`=1, `hazard_cnt`=0.
- **Memory wait:** `mem_req`=1, `mem_ready`=0 for 3 cycles, then `mem_ready`=1 with `branch_taken`=1 → all freezes are 1 for 3 cycles. On the release cycle the flushes assert and the freezes are 0. `mem_wait_cnt`=3.
- **Timeout:** TIMEOUT=4 with `mem_stall` held for 10 cycles → `mem_timeout` is 1 from cycle 5 and stays 1 after `mem_ready`=1. `rst` pulse → back to RUN and `mem_timeout`=0.
- **Counter saturation:** CNT_W=3, `hazard` held for 10 cycles → `hazard_cnt` stops at 7.
